instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
Inverse of the control decoder. Accepts symbolic instructions (opcode plus register, function and immediate fields), packs each into a 16-bit WISC instruction word using the format implied by the opcode, and buffers the words in a small FIFO. It drains the FIFO into instruction memory at consecutive word addresses. Used as the bench/boot-time program loader ahead of the fetch stage; stops after encoding HALT.

Parameters:
DEPTH, 4, FIFO entries (power of two, >=2)
ADDR_W, 16, memory address width
BASE_ADDR, 16'h0000, byte address of the first word written

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset; synchronous, active-low
in_valid  in  1  symbolic instruction present
in_ready  out  1  encoder can accept
in_op  in  5  opcode, same encoding as instr[15:11]
in_rs  in  3  source reg 1
in_rt  in  3  source reg 2 (R-format only)
in_rd  in  3  destination reg
in_func  in  2  R-format function bits [1:0]
in_imm  in  16  immediate/displacement, two's complement
mem_wr  out  1  write strobe to instruction memory
mem_addr  out  ADDR_W  byte address
mem_data  out  16  encoded word
mem_ready  in  1  memory accepts write this cycle
done  out  1  HALT written, loader idle
err  out  1  sticky immediate-range error
word_count  out  16  words written since reset

Behaviour:
- Reset (rst==0 at clk edge): FIFO empty, state RUN, mem_addr=BASE_ADDR, mem_wr=0, mem_data=0, done=0, err=0, word_count=0. in_ready=1 the cycle after reset is released.
- Accept on in_valid & in_ready. Encoding is combinational and written to the FIFO tail in the same cycle.
- Formats (bits [15:11]=in_op in all cases):
  - No-operand (00000 HALT, 00001 NOP, 00010 SIIC, 00011 RTI): [10:0]=0.
  - J-format (00100 J, 00110 JAL): [10:0]=in_imm[10:0].
  - I-format 2 (00101, 00111, 011xx, 11000, 10010): [10:8]=rs, [7:0]=imm[7:0].
  - R-format (11001, 11011, 11010, 111xx): [10:8]=rs, [7:5]=rt, [4:2]=rd, [1:0]=func. BTR ignores rt; the field is still packed.
  - I-format 1 (010xx, 101xx, 10000, 10001, 10011): [10:8]=rs, [7:5]=rd, [4:0]=imm[4:0].
- Truncation: the immediate is truncated to its field width.
- in_ready:
  - in_ready = (state==RUN) & ~fifo_full. Full is evaluated before this cycle's pop, so there is no same-cycle bypass.
  - When full with a pop in the same cycle, in_ready is still 0.
- Output side:
  - mem_wr = ~fifo_empty.
  - mem_data = FIFO head; mem_addr = current address register.
  - When mem_wr & mem_ready: pop, mem_addr += 2 (wraps modulo 2^ADDR_W), word_count += 1 (saturates at 16'hFFFF).
  - mem_data and mem_addr hold stable while mem_wr & ~mem_ready.
- Latency: a word accepted in cycle N appears on mem_data with mem_wr=1 in cycle N+1 at the earliest.
- Simultaneous push and pop: occupancy is unchanged; FIFO order is preserved.
- FSM:
  - RUN -> DRAIN when a HALT (in_op==00000) is accepted.
  - DRAIN: in_ready=0; -> DONE when the FIFO is empty after a pop.
  - DONE: done=1, mem_wr=0, in_ready=0; held until reset.
- Reset mid-operation discards FIFO contents and returns all outputs to reset values; no partial write is completed.
- Opcode values not listed above (none exist in 5 bits): treated as no-operand.

Optional Feature:
RANGE_CHECK_EN:
- Defined: on accept, in_imm is checked against its field.
  - Signed fields (ADDI, SUBI, ST, LD, STU, branches, LBI, JR, JALR, J, JAL): imm must lie in [-2^(w-1), 2^(w-1)-1].
  - Unsigned fields (XORI, ANDNI, SLBI): imm must lie in [0, 2^w-1].
  - Shift immediates (ROLI..SRLI): imm must lie in 0..15.
  - On violation err is set and stays set until reset; the truncated word is still encoded and written.
- Undefined: no check; err is tied to 0.

Test Plan:
- ADDI rd=1 rs=2 imm=3; ADD (op 11011) rs=1 rt=2 rd=3 func=00 -> mem writes 0x4223 @0x0000, 0xD94C @0x0002; word_count=2.
- J imm=-2; LBI rs=4 imm=-1; HALT -> 0x27FE, 0xC4FF, 0x0000 at 0x0,0x2,0x4. in_ready=0 from the cycle after HALT is accepted; done=1 after the last write; in_valid afterwards is ignored.
- mem_ready=0 while pushing DEPTH+1 words -> in_ready drops after DEPTH accepts, mem_data/mem_addr hold. Then mem_ready=1 -> all words written in order at consecutive addresses.
- ADDI rs=2 rd=1 imm=16 -> word 0x4230. With RANGE_CHECK_EN, err=1 and stays 1; without, err=0.
- rst=0 asserted mid-stream with 3 words queued -> next cycle mem_wr=0, mem_addr=BASE_ADDR, word_count=0. The next accepted word is written at BASE_ADDR.
- Simultaneous push/pop with FIFO full-1 for 10 cycles at mem_ready=1 -> occupancy constant, 10 sequential addresses, no drop or duplicate.

Source files
------------

// File: rtl/instr_encoder.sv
// instr_encoder: packs symbolic WISC instructions into 16-bit words, queues
// them in a DEPTH-entry FIFO and streams them to instruction memory at
// consecutive byte addresses starting at BASE_ADDR. Stops after HALT.
// Optional build macro: RANGE_CHECK_EN (immediate range checking -> err).
module instr_encoder #(
    parameter int unsigned       DEPTH     = 4,
    parameter int unsigned       ADDR_W    = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_op,
    input  logic [2:0]        in_rs,
    input  logic [2:0]        in_rt,
    input  logic [2:0]        in_rd,
    input  logic [1:0]        in_func,
    input  logic [15:0]       in_imm,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_data,
    input  logic              mem_ready,
    output logic              done,
    output logic              err,
    output logic [15:0]       word_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {S_RUN, S_DRAIN, S_DONE} state_t;

    state_t             state, state_nxt;
    logic [15:0]        fifo [DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               fifo_empty, fifo_full;
    logic               push, pop;
    logic [15:0]        enc;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CNT_W'(DEPTH));
    assign push       = in_valid & in_ready;
    assign pop        = mem_wr & mem_ready;
    assign mem_data   = fifo_empty ? '0 : fifo[rd_ptr];

    // Combinational instruction packing; format selected by opcode
    always_comb begin
        enc        = '0;
        enc[15:11] = in_op;
        casez (in_op)
            5'b000??: ;                                   // HALT/NOP/SIIC/RTI
            5'b001?0: enc[10:0] = in_imm[10:0];           // J, JAL
            5'b001?1, 5'b011??, 5'b11000, 5'b10010: begin // JR, JALR, branches, LBI, SLBI
                enc[10:8] = in_rs;
                enc[7:0]  = in_imm[7:0];
            end
            5'b110?1, 5'b11010, 5'b111??: begin           // BTR, ALU, shift, compare
                enc[10:8] = in_rs;
                enc[7:5]  = in_rt;
                enc[4:2]  = in_rd;
                enc[1:0]  = in_func;
            end
            default: begin                                // 010xx, 101xx, ST, LD, STU
                enc[10:8] = in_rs;
                enc[7:5]  = in_rd;
                enc[4:0]  = in_imm[4:0];
            end
        endcase
    end

    // FIFO storage; entries need no reset since occupancy is tracked by count
    always_ff @(posedge clk) begin
        if (push)
            fifo[wr_ptr] <= enc;
    end

    // Pointers, occupancy, address, word counter and FSM state register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_RUN;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            mem_addr   <= BASE_ADDR;
            word_count <= '0;
        end else begin
            state <= state_nxt;
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop) begin
                rd_ptr   <= rd_ptr + PTR_W'(1);
                mem_addr <= mem_addr + ADDR_W'(2);
                if (word_count != 16'hFFFF)
                    word_count <= word_count + 16'd1;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        mem_wr    = 1'b0;
        done      = 1'b0;
        case (state)
            S_RUN: begin
                in_ready = ~fifo_full;
                mem_wr   = ~fifo_empty;
                if (in_valid && !fifo_full && in_op == 5'b00000)
                    state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                mem_wr = ~fifo_empty;
                if (!fifo_empty && mem_ready && count == CNT_W'(1))
                    state_nxt = S_DONE;
            end
            default: begin
                done = 1'b1;
            end
        endcase
    end

`ifdef RANGE_CHECK_EN
    logic imm_bad;

    // Immediate range check against the field the opcode selects
    always_comb begin
        imm_bad = 1'b0;
        casez (in_op)
            5'b001?0:                     // J, JAL: signed 11
                imm_bad = !((in_imm[15:10] == '0) || (in_imm[15:10] == '1));
            5'b001?1, 5'b011??, 5'b11000: // JR, JALR, branches, LBI: signed 8
                imm_bad = !((in_imm[15:7] == '0) || (in_imm[15:7] == '1));
            5'b10010:                     // SLBI: unsigned 8
                imm_bad = (in_imm[15:8] != '0);
            5'b0100?, 5'b100??:           // ADDI, SUBI, ST, LD, STU: signed 5
                imm_bad = !((in_imm[15:4] == '0) || (in_imm[15:4] == '1));
            5'b0101?:                     // XORI, ANDNI: unsigned 5
                imm_bad = (in_imm[15:5] != '0);
            5'b101??:                     // rotate/shift amounts 0..15
                imm_bad = (in_imm[15:4] != '0);
            default: imm_bad = 1'b0;
        endcase
    end

    // Sticky range error, cleared only by reset
    always_ff @(posedge clk) begin
        if (!rst)
            err <= 1'b0;
        else if (push && imm_bad)
            err <= 1'b1;
    end
`else
    logic unused_imm_hi;
    assign unused_imm_hi = ^in_imm[15:11];
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder (DEPTH=4, BASE_ADDR=0).
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_op;
    logic [2:0]  in_rs, in_rt, in_rd;
    logic [1:0]  in_func;
    logic [15:0] in_imm;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_data;
    logic        mem_ready;
    logic        done;
    logic        err;
    logic [15:0] word_count;

    int unsigned tests = 0;
    int unsigned fails = 0;
    logic [15:0] wr_addr[$];
    logic [15:0] wr_data[$];

`ifdef RANGE_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    instr_encoder #(.DEPTH(4), .ADDR_W(16), .BASE_ADDR(16'h0000)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_func(in_func), .in_imm(in_imm), .mem_wr(mem_wr),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready),
        .done(done), .err(err), .word_count(word_count)
    );

    always #5 clk = ~clk;

    // Record every write that the coming rising edge will complete
    always @(negedge clk) begin
        if (rst && mem_wr && mem_ready) begin
            wr_addr.push_back(mem_addr);
            wr_data.push_back(mem_data);
        end
    end

    function automatic logic [15:0] get_d(input int unsigned i);
        return (wr_data.size() > i) ? wr_data[i] : 16'hxxxx;
    endfunction

    function automatic logic [15:0] get_a(input int unsigned i);
        return (wr_addr.size() > i) ? wr_addr[i] : 16'hxxxx;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        wr_addr.delete();
        wr_data.delete();
    endtask

    task automatic set_fields(input logic [4:0] op, input logic [2:0] rs, input logic [2:0] rt,
                              input logic [2:0] rd, input logic [1:0] fn, input logic [15:0] imm);
        in_op = op; in_rs = rs; in_rt = rt; in_rd = rd; in_func = fn; in_imm = imm;
    endtask

    // Present one instruction and hold it until accepted (bounded)
    task automatic send(input logic [4:0] op, input logic [2:0] rs, input logic [2:0] rt,
                        input logic [2:0] rd, input logic [1:0] fn, input logic [15:0] imm);
        int unsigned n = 0;
        set_fields(op, rs, rt, rd, fn, imm);
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            tests++; fails++;
            $display("FAIL send_timeout op=%b in_ready=%b required 1", op, in_ready);
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_writes(input int unsigned n);
        int unsigned k = 0;
        while (wr_data.size() < n && k < 100) begin
            tick();
            k++;
        end
        if (wr_data.size() < n) begin
            tests++; fails++;
            $display("FAIL write_timeout got %0d writes required %0d", wr_data.size(), n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; in_valid = 1'b0; mem_ready = 1'b1;
        set_fields(5'd0, 3'd0, 3'd0, 3'd0, 2'd0, 16'd0);
        tick(); tick();
        tests++; if (mem_wr !== 1'b0)      begin fails++; $display("FAIL rst_mem_wr got %b exp 0", mem_wr); end
        tests++; if (mem_addr !== 16'h0)   begin fails++; $display("FAIL rst_mem_addr got %h exp 0000", mem_addr); end
        tests++; if (mem_data !== 16'h0)   begin fails++; $display("FAIL rst_mem_data got %h exp 0000", mem_data); end
        tests++; if (done !== 1'b0)        begin fails++; $display("FAIL rst_done got %b exp 0", done); end
        tests++; if (err !== 1'b0)         begin fails++; $display("FAIL rst_err got %b exp 0", err); end
        tests++; if (word_count !== 16'd0) begin fails++; $display("FAIL rst_word_count got %0d exp 0", word_count); end
        rst = 1'b1;
        tests++; if (in_ready !== 1'b1)    begin fails++; $display("FAIL rst_in_ready got %b exp 1", in_ready); end
        wr_addr.delete(); wr_data.delete();
    endtask

    task automatic test_basic();
        send(5'b01000, 3'd2, 3'd0, 3'd1, 2'd0, 16'd3);   // ADDI
        send(5'b11011, 3'd1, 3'd2, 3'd3, 2'b00, 16'd0);  // ADD
        wait_writes(2);
        tests++; if (get_d(0) !== 16'h4223) begin fails++; $display("FAIL basic_d0 got %h exp 4223", get_d(0)); end
        tests++; if (get_a(0) !== 16'h0000) begin fails++; $display("FAIL basic_a0 got %h exp 0000", get_a(0)); end
        tests++; if (get_d(1) !== 16'hD94C) begin fails++; $display("FAIL basic_d1 got %h exp d94c", get_d(1)); end
        tests++; if (get_a(1) !== 16'h0002) begin fails++; $display("FAIL basic_a1 got %h exp 0002", get_a(1)); end
        tests++; if (word_count !== 16'd2)  begin fails++; $display("FAIL basic_count got %0d exp 2", word_count); end
    endtask

    task automatic test_backpressure();
        do_reset();
        mem_ready = 1'b0;
        for (int unsigned i = 1; i <= 4; i++)
            send(5'b01000, 3'd0, 3'd0, 3'd0, 2'd0, 16'(i));
        set_fields(5'b01000, 3'd0, 3'd0, 3'd0, 2'd0, 16'd5);
        in_valid = 1'b1;
        for (int unsigned c = 0; c < 3; c++) begin
            tests++; if (in_ready !== 1'b0)     begin fails++; $display("FAIL bp_in_ready got %b exp 0", in_ready); end
            tests++; if (mem_wr !== 1'b1)       begin fails++; $display("FAIL bp_mem_wr got %b exp 1", mem_wr); end
            tests++; if (mem_data !== 16'h4001) begin fails++; $display("FAIL bp_hold_data got %h exp 4001", mem_data); end
            tests++; if (mem_addr !== 16'h0000) begin fails++; $display("FAIL bp_hold_addr got %h exp 0000", mem_addr); end
            tick();
        end
        mem_ready = 1'b1;
        send(5'b01000, 3'd0, 3'd0, 3'd0, 2'd0, 16'd5);
        wait_writes(5);
        for (int unsigned i = 0; i < 5; i++) begin
            tests++; if (get_d(i) !== 16'h4001 + 16'(i)) begin fails++; $display("FAIL bp_data[%0d] got %h exp %h", i, get_d(i), 16'h4001 + 16'(i)); end
            tests++; if (get_a(i) !== 16'(2 * i))        begin fails++; $display("FAIL bp_addr[%0d] got %h exp %h", i, get_a(i), 16'(2 * i)); end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        mem_ready = 1'b0;
        for (int unsigned i = 0; i < 3; i++)
            send(5'b01000, 3'd0, 3'd0, 3'd0, 2'd0, 16'(i));
        mem_ready = 1'b1;
        for (int unsigned i = 3; i < 13; i++) begin
            set_fields(5'b01000, 3'd0, 3'd0, 3'd0, 2'd0, 16'(i));
            in_valid = 1'b1;
            @(negedge clk);
            tests++; if (in_ready !== 1'b1 || mem_wr !== 1'b1) begin
                fails++; $display("FAIL b2b_flow[%0d] got ready=%b wr=%b exp 1 1", i, in_ready, mem_wr);
            end
            tick();
        end
        in_valid = 1'b0;
        wait_writes(13);
        tick();
        tests++; if (wr_data.size() !== 13) begin fails++; $display("FAIL b2b_nwrites got %0d exp 13", wr_data.size()); end
        for (int unsigned i = 0; i < 13; i++) begin
            tests++; if (get_d(i) !== 16'h4000 + 16'(i) || get_a(i) !== 16'(2 * i)) begin
                fails++; $display("FAIL b2b_word[%0d] got %h@%h exp %h@%h", i, get_d(i), get_a(i), 16'h4000 + 16'(i), 16'(2 * i));
            end
        end
    endtask

    task automatic test_range();
        do_reset();
        send(5'b01000, 3'd2, 3'd0, 3'd1, 2'd0, 16'd15);     // max legal
        send(5'b01000, 3'd2, 3'd0, 3'd1, 2'd0, 16'hFFF0);   // -16, min legal
        wait_writes(2);
        tests++; if (get_d(0) !== 16'h422F) begin fails++; $display("FAIL rng_d0 got %h exp 422f", get_d(0)); end
        tests++; if (get_d(1) !== 16'h4230) begin fails++; $display("FAIL rng_d1 got %h exp 4230", get_d(1)); end
        tests++; if (err !== 1'b0)          begin fails++; $display("FAIL rng_err_legal got %b exp 0", err); end
        send(5'b01000, 3'd2, 3'd0, 3'd1, 2'd0, 16'd16);     // out of range, truncated
        wait_writes(3);
        tests++; if (get_d(2) !== 16'h4230) begin fails++; $display("FAIL rng_trunc got %h exp 4230", get_d(2)); end
        tests++; if (err !== EXP_ERR)       begin fails++; $display("FAIL rng_err_set got %b exp %b", err, EXP_ERR); end
        send(5'b10101, 3'd1, 3'd0, 3'd2, 2'd0, 16'd15);     // SLLI 15, legal
        wait_writes(4);
        tests++; if (get_d(3) !== 16'hA94F) begin fails++; $display("FAIL rng_slli got %h exp a94f", get_d(3)); end
        tests++; if (err !== EXP_ERR)       begin fails++; $display("FAIL rng_err_sticky got %b exp %b", err, EXP_ERR); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        mem_ready = 1'b0;
        for (int unsigned i = 1; i <= 3; i++)
            send(5'b01000, 3'd0, 3'd0, 3'd0, 2'd0, 16'(i));
        rst = 1'b0;
        tick();
        tests++; if (mem_wr !== 1'b0)      begin fails++; $display("FAIL mid_mem_wr got %b exp 0", mem_wr); end
        tests++; if (mem_addr !== 16'h0)   begin fails++; $display("FAIL mid_mem_addr got %h exp 0000", mem_addr); end
        tests++; if (word_count !== 16'd0) begin fails++; $display("FAIL mid_count got %0d exp 0", word_count); end
        tests++; if (err !== 1'b0)         begin fails++; $display("FAIL mid_err got %b exp 0", err); end
        rst = 1'b1;
        mem_ready = 1'b1;
        wr_addr.delete(); wr_data.delete();
        send(5'b01000, 3'd0, 3'd0, 3'd0, 2'd0, 16'd7);
        wait_writes(1);
        tick();
        tests++; if (get_d(0) !== 16'h4007 || get_a(0) !== 16'h0000) begin
            fails++; $display("FAIL mid_first got %h@%h exp 4007@0000", get_d(0), get_a(0));
        end
        tests++; if (wr_data.size() !== 1) begin fails++; $display("FAIL mid_nwrites got %0d exp 1", wr_data.size()); end
    endtask

    task automatic test_halt();
        int unsigned k = 0;
        do_reset();
        send(5'b00100, 3'd0, 3'd0, 3'd0, 2'd0, 16'hFFFE);   // J -2
        send(5'b11000, 3'd4, 3'd0, 3'd0, 2'd0, 16'hFFFF);   // LBI r4,-1
        send(5'b00000, 3'd0, 3'd0, 3'd0, 2'd0, 16'd0);      // HALT
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL halt_in_ready got %b exp 0", in_ready); end
        while (!done && k < 50) begin tick(); k++; end
        tests++; if (done !== 1'b1) begin fails++; $display("FAIL halt_done got %b exp 1", done); end
        tests++; if (get_d(0) !== 16'h27FE || get_a(0) !== 16'h0000) begin fails++; $display("FAIL halt_w0 got %h@%h exp 27fe@0000", get_d(0), get_a(0)); end
        tests++; if (get_d(1) !== 16'hC4FF || get_a(1) !== 16'h0002) begin fails++; $display("FAIL halt_w1 got %h@%h exp c4ff@0002", get_d(1), get_a(1)); end
        tests++; if (get_d(2) !== 16'h0000 || get_a(2) !== 16'h0004) begin fails++; $display("FAIL halt_w2 got %h@%h exp 0000@0004", get_d(2), get_a(2)); end
        set_fields(5'b00001, 3'd0, 3'd0, 3'd0, 2'd0, 16'd0);
        in_valid = 1'b1;
        for (int unsigned c = 0; c < 4; c++) begin
            tests++; if (in_ready !== 1'b0 || mem_wr !== 1'b0 || done !== 1'b1) begin
                fails++; $display("FAIL halt_idle got ready=%b wr=%b done=%b exp 0 0 1", in_ready, mem_wr, done);
            end
            tick();
        end
        in_valid = 1'b0;
        tests++; if (word_count !== 16'd3)  begin fails++; $display("FAIL halt_count got %0d exp 3", word_count); end
        tests++; if (wr_data.size() !== 3)  begin fails++; $display("FAIL halt_nwrites got %0d exp 3", wr_data.size()); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_range();
        test_reset_mid();
        test_halt();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
